// File: rtl/fwd_pipe_pkg.sv
// Shared widths, defaults and the per-stage entry record for the forwarding pipe.
package pipe_pkg;

  localparam int DATA_W       = 64;
  localparam int REG_AW       = 5;
  localparam int DEF_DEPTH    = 3;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_ZERO_REG = 31;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_t;

  typedef struct packed {
    logic  valid;
    reg_t  rd;
    logic  we;
    logic  load;
    logic  ready;
    data_t data;
  } entry_t;

  localparam entry_t ENTRY_RST = '0;

  // A destination that is the hard-wired zero register carries no architectural value.
  function automatic logic reg_live(input reg_t r, input int zero_reg);
    return r != REG_AW'(zero_reg);
  endfunction

endpackage

// File: rtl/fwd_pipe_if.sv
// Decode-side bundle: instruction fields, operand reads, pipeline results and writeback.
interface fwd_pipe_if;
  import pipe_pkg::*;

  logic  id_valid;
  reg_t  id_rd;
  logic  id_regwrite;
  logic  id_load;
  reg_t  id_rs1;
  reg_t  id_rs2;
  data_t id_rf1;
  data_t id_rf2;
  logic  flush;
  data_t ex_result;
  data_t mem_rdata;
  data_t id_op1;
  data_t id_op2;
  logic  stall;
  logic  wb_we;
  reg_t  wb_rd;
  data_t wb_data;

  modport master (
    output id_valid, id_rd, id_regwrite, id_load, id_rs1, id_rs2,
    output id_rf1, id_rf2, flush, ex_result, mem_rdata,
    input  id_op1, id_op2, stall, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  id_valid, id_rd, id_regwrite, id_load, id_rs1, id_rs2,
    input  id_rf1, id_rf2, flush, ex_result, mem_rdata,
    output id_op1, id_op2, stall, wb_we, wb_rd, wb_data
  );

endinterface

// File: rtl/fwd_pipe_match.sv
// Youngest-first match of one source register against all tracked stages.
// Purely combinational; the lowest stage index that writes the register wins.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic [DEPTH-1:0] cand_i,
  input  reg_t             rd_i  [DEPTH],
  input  logic [DEPTH-1:0] rdy_i,
  input  data_t            val_i [DEPTH],
  input  reg_t             rs_i,
  output logic             hit_o,
  output logic             ready_o,
  output data_t            value_o
);

  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    value_o = '0;
    if (reg_live(rs_i, ZERO_REG)) begin
      // Scan oldest to youngest so the youngest match overwrites.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (cand_i[k] && (rd_i[k] == rs_i)) begin
          hit_o   = 1'b1;
          ready_o = rdy_i[k];
          value_o = val_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_pipe.sv
// Post-decode pipeline tracker: forwards youngest ready results to decode operands,
// raises load-use stall, and drives the register-file write port from the last stage.
module fwd_pipe
  import pipe_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic       clk,
  input  logic       reset,
  fwd_pipe_if.slave  bus
);

  entry_t stage_q [DEPTH];
  entry_t stage_d [DEPTH];

  logic [DEPTH-1:0] val_rdy;
  data_t            val_dat [DEPTH];
  logic [DEPTH-1:0] cand;
  reg_t             cand_rd [DEPTH];

  logic  hit1, rdy1, hit2, rdy2;
  data_t fv1, fv2;
  logic  hz1, hz2, stall_w, accept;

  // Value each stage can offer this cycle: live ALU result, arriving load data, or captured.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      cand[k]    = stage_q[k].valid & stage_q[k].we;
      cand_rd[k] = stage_q[k].rd;
      val_rdy[k] = stage_q[k].ready;
      val_dat[k] = stage_q[k].data;
      if ((k == 0) && !stage_q[k].load) begin
        val_rdy[k] = 1'b1;
        val_dat[k] = bus.ex_result;
      end else if ((k == LOAD_LAT) && stage_q[k].load) begin
        val_rdy[k] = 1'b1;
        val_dat[k] = bus.mem_rdata;
      end
    end
  end

  fwd_match #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_match1 (
    .cand_i  (cand),
    .rd_i    (cand_rd),
    .rdy_i   (val_rdy),
    .val_i   (val_dat),
    .rs_i    (bus.id_rs1),
    .hit_o   (hit1),
    .ready_o (rdy1),
    .value_o (fv1)
  );

  fwd_match #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_match2 (
    .cand_i  (cand),
    .rd_i    (cand_rd),
    .rdy_i   (val_rdy),
    .val_i   (val_dat),
    .rs_i    (bus.id_rs2),
    .hit_o   (hit2),
    .ready_o (rdy2),
    .value_o (fv2)
  );

  assign hz1     = hit1 & ~rdy1;
  assign hz2     = hit2 & ~rdy2;
  assign stall_w = bus.id_valid & ~bus.flush & (hz1 | hz2);
  assign accept  = bus.id_valid & ~bus.flush & ~stall_w;

  assign bus.stall  = stall_w;
  assign bus.id_op1 = (hit1 & rdy1) ? fv1 : bus.id_rf1;
  assign bus.id_op2 = (hit2 & rdy2) ? fv2 : bus.id_rf2;

  always_comb begin
    stage_d[0] = ENTRY_RST;
    if (accept) begin
      stage_d[0].valid = 1'b1;
      stage_d[0].rd    = bus.id_rd;
      stage_d[0].we    = bus.id_regwrite;
      stage_d[0].load  = bus.id_load;
    end
    // Bubbles travel as all-zero so an empty WB stage presents rd=0, data=0.
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = ENTRY_RST;
      if (stage_q[k-1].valid) begin
        stage_d[k].valid = 1'b1;
        stage_d[k].rd    = stage_q[k-1].rd;
        stage_d[k].we    = stage_q[k-1].we;
        stage_d[k].load  = stage_q[k-1].load;
        stage_d[k].ready = val_rdy[k-1];
        stage_d[k].data  = val_dat[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset) begin
        stage_q[k] <= ENTRY_RST;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Write suppressed while reset is held so the discarded WB entry never lands.
  assign bus.wb_we   = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].we &
                       reg_live(stage_q[DEPTH-1].rd, ZERO_REG) & ~reset;
  assign bus.wb_rd   = stage_q[DEPTH-1].rd;
  assign bus.wb_data = stage_q[DEPTH-1].data;

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed plus random stimulus for fwd_pipe against an instruction-level reference model.
module tb_fwd_pipe;
  import pipe_pkg::*;

  localparam int DEPTH = 3;
  localparam int LL    = 1;
  localparam int ZR    = 31;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_pipe_if bus ();

  fwd_pipe #(.DEPTH(DEPTH), .LOAD_LAT(LL), .ZERO_REG(ZR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          issue;
    logic [4:0]  rd;
    bit          we;
    bit          load;
    bit          known;
    logic [63:0] val;
  } instr_t;

  instr_t q[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;
  bit     exp_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input bit rw, input bit ld,
                       input logic [4:0] r1, input logic [4:0] r2, input bit fl);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_load     = ld;
    bus.id_rs1      = r1;
    bus.id_rs2      = r2;
    bus.flush       = fl;
    bus.id_rf1      = {$urandom, $urandom};
    bus.id_rf2      = {$urandom, $urandom};
    bus.ex_result   = {$urandom, $urandom};
    bus.mem_rdata   = {$urandom, $urandom};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 5'd11, 1'b0);
  endtask

  // Youngest in-flight writer of rs (largest issue time) supplies the value if it is known.
  task automatic lookup(input logic [4:0] rs, input logic [63:0] rf,
                        output logic [63:0] val, output bit hz);
    int best;
    best = -1;
    val  = rf;
    hz   = 1'b0;
    if (rs != 5'(ZR)) begin
      foreach (q[i]) begin
        if (q[i].we && q[i].rd == rs && q[i].issue > best) begin
          best = q[i].issue;
          hz   = !q[i].known;
          val  = q[i].known ? q[i].val : rf;
        end
      end
    end
  endtask

  task automatic settle_check();
    logic [63:0] e1, e2, ed;
    bit          h1, h2, ewe;
    logic [4:0]  erd;
    int          s;
    #2;
    foreach (q[i]) begin
      s = cyc - q[i].issue;
      if (!q[i].load && s == 0) begin
        q[i].val = bus.ex_result; q[i].known = 1'b1;
      end
      if (q[i].load && s == LL) begin
        q[i].val = bus.mem_rdata; q[i].known = 1'b1;
      end
    end
    lookup(bus.id_rs1, bus.id_rf1, e1, h1);
    lookup(bus.id_rs2, bus.id_rf2, e2, h2);
    exp_stall = bus.id_valid && !bus.flush && (h1 || h2);
    ewe = 1'b0; erd = '0; ed = '0;
    foreach (q[i]) begin
      if (cyc - q[i].issue == DEPTH - 1) begin
        ewe = q[i].we && q[i].rd != 5'(ZR) && !reset;
        erd = q[i].rd;
        ed  = q[i].val;
      end
    end
    chk("op1", bus.id_op1, e1);
    chk("op2", bus.id_op2, e2);
    chk("stall", bus.stall, exp_stall);
    chk("wb_we", bus.wb_we, ewe);
    chk("wb_rd", bus.wb_rd, erd);
    chk("wb_data", bus.wb_data, ed);
  endtask

  task automatic tick();
    instr_t n;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else if (bus.id_valid && !exp_stall && !bus.flush) begin
      n.issue = cyc + 1; n.rd = bus.id_rd; n.we = bus.id_regwrite;
      n.load = bus.id_load; n.known = 1'b0; n.val = '0;
      q.push_back(n);
    end
    cyc++;
    while (q.size() > 0 && cyc - q[0].issue >= DEPTH) void'(q.pop_front());
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    // Reset state with reset still held
    settle_check();
    chk("rst_wb_we", bus.wb_we, 1'b0);
    tick();
    reset = 1'b0;

    // Back-to-back ALU dependence
    drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd8, 5'd9, 1'b0);
    settle_check(); tick();
    drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd1, 5'd9, 1'b0);
    bus.ex_result = 64'h10;
    settle_check();
    chk("alu_fwd_op1", bus.id_op1, 64'h10);
    chk("alu_fwd_stall", bus.stall, 1'b0);
    tick();

    // Load-use: one stall cycle, then mem_rdata forwarded
    drive(1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 5'd9, 1'b0);
    settle_check(); tick();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd8, 5'd2, 1'b0);
    settle_check();
    chk("ldu_stall", bus.stall, 1'b1);
    tick();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd8, 5'd2, 1'b0);
    bus.mem_rdata = 64'hDEAD;
    settle_check();
    chk("ldu_op2", bus.id_op2, 64'hDEAD);
    chk("ldu_stall_clr", bus.stall, 1'b0);
    tick();

    // Youngest wins: X3=5 then X3=7
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd8, 5'd9, 1'b0);
    settle_check(); tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd8, 5'd9, 1'b0);
    bus.ex_result = 64'd5;
    settle_check(); tick();
    idle();
    bus.ex_result = 64'd7;
    settle_check(); tick();
    drive(1'b1, 5'd14, 1'b0, 1'b0, 5'd3, 5'd9, 1'b0);
    settle_check();
    chk("young_op1", bus.id_op1, 64'd7);
    chk("young_wb_we", bus.wb_we, 1'b1);
    chk("young_wb_rd", bus.wb_rd, 64'd3);
    chk("young_wb_data", bus.wb_data, 64'd5);
    tick();

    // Zero register: never forwarded, never written
    drive(1'b1, 5'd31, 1'b1, 1'b0, 5'd8, 5'd9, 1'b0);
    settle_check(); tick();
    drive(1'b1, 5'd15, 1'b0, 1'b0, 5'd31, 5'd31, 1'b0);
    bus.id_rf1 = '0; bus.id_rf2 = '0;
    settle_check();
    chk("xzr_op1", bus.id_op1, 64'd0);
    chk("xzr_op2", bus.id_op2, 64'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      settle_check();
      chk("xzr_wb_we", bus.wb_we, 1'b0);
      tick();
    end

    // Flush with a pending hazard
    drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd8, 5'd9, 1'b0);
    settle_check(); tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 5'd9, 1'b1);
    settle_check();
    chk("flush_stall", bus.stall, 1'b0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      settle_check();
      if (i == DEPTH - 1) chk("flush_no_wb", bus.wb_we, 1'b0);
      tick();
    end

    // Reset with three entries in flight
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 1'b1, 1'b0, 5'd8, 5'd9, 1'b0);
      settle_check(); tick();
    end
    reset = 1'b1;
    idle();
    settle_check();
    chk("rst_mid_wb_we", bus.wb_we, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      settle_check();
      chk("post_rst_wb_we", bus.wb_we, 1'b0);
      chk("post_rst_wb_rd", bus.wb_rd, 64'd0);
      chk("post_rst_wb_data", bus.wb_data, 64'd0);
      chk("post_rst_stall", bus.stall, 1'b0);
      tick();
    end

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, r1, r2;
      logic [4:0] pick [5];
      pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2; pick[3] = 5'd3; pick[4] = 5'd31;
      rd = pick[$urandom_range(0, 4)];
      r1 = pick[$urandom_range(0, 4)];
      r2 = pick[$urandom_range(0, 4)];
      drive($urandom_range(0, 9) < 8, rd, $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 3, r1, r2, $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      settle_check();
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_pipe.md
# fwd_pipe

Parametrised post-decode pipeline tracker and operand bypass network for the pipelined CPU. It holds destination register, write-enable, load flag and result for every in-flight instruction from EX through WB. It forwards the youngest ready value to the decode-stage operands and raises a load-use stall when the needed value is not yet available. It also drives the register-file write port. Unlike the fixed 3-stage forwarding muxes, depth, data width and load latency are generic, and stall/flush bubbles are generated internally.

## Interface
- DATA_W, 64, operand/result width
- REG_AW, 5, register address width
- DEPTH, 3, tracked stages (0 = EX … DEPTH-1 = WB); must be ≥ LOAD_LAT+2
- LOAD_LAT, 1, stage index at which load data arrives (MEM)
- ZERO_REG, 31, register never forwarded and never written
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_rd  in  REG_AW  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_load  in  1  result comes from memory
- id_rs1, id_rs2  in  REG_AW  source registers
- id_rf1, id_rf2  in  DATA_W  register-file read data
- flush  in  1  kill the decode instruction (branch taken)
- ex_result  in  DATA_W  ALU/math result of the stage-0 entry
- mem_rdata  in  DATA_W  load data for the stage-LOAD_LAT entry
- id_op1, id_op2  out  DATA_W  forwarded operands
- stall  out  1  hold fetch/decode this cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  REG_AW  write address
- wb_data  out  DATA_W  write data

## Operation
- Each stage entry holds: valid, rd, we, load, ready, data.
- Stage value: stage 0 non-load → ex_result, ready. Stage LOAD_LAT load → mem_rdata, ready. Stage 0 load → not ready. Stage ≥ 1 non-load → captured data. Stage > LOAD_LAT load → captured data.
- Operand k is a match if entry valid & we & rd == id_rsk & id_rsk ≠ ZERO_REG. The lowest stage index (youngest) wins.
- Operand output:
  - no match → id_rfk;
  - match ready → that stage value;
  - match not ready → id_rfk, and stall=1.
- stall = id_valid & ~flush & (op1 hazard | op2 hazard).
- The pipe always advances: stage k+1 ← stage k, with data ← stage value and ready=1 when the value was available.
- Stage 0 ← decode instruction if id_valid & ~stall & ~flush. Otherwise stage 0 receives a bubble (valid=0).
- Writeback: wb_we = valid & we & rd ≠ ZERO_REG of stage DEPTH-1. wb_rd and wb_data are that entry's rd and data.
- An entry with rd = ZERO_REG never matches and never writes.

## Timing
- Reset: all valid=0, rd=0, data=0. Hence wb_we=0, wb_rd=0, wb_data=0, stall=0. id_op* pass id_rf*.
- Reset asserted mid-operation discards every in-flight entry at that edge. No writeback occurs in the reset cycle's following edge.
- An instruction accepted at edge t occupies stage 0 in cycle t+1 and stage DEPTH-1 in cycle t+DEPTH. The register file writes at the end of that cycle.
- The WB stage is included in matching, so same-cycle read/write needs no regfile write-through.
- Load-use with default parameters: consumer immediately after a load stalls exactly 1 cycle. A consumer two behind gets mem_rdata with no stall.
- flush and a hazard in the same cycle → bubble, stall=0.
- Both operands on the same register → both forwarded identically.

## Structure
- `pipe_pkg`: entry struct typedef (valid, rd, we, load, ready, data), parameterised by DATA_W/REG_AW via package constants, plus the default DEPTH, LOAD_LAT and ZERO_REG.
- Sub-module `fwd_match`: combinational youngest-first priority match over the DEPTH entries for one source register. It returns hit, ready and value, and is instantiated once per operand.
- Stage storage is an array of entries in the top module.

## Test plan
- Back-to-back ALU dependence: ADD X1 (ex_result=0x10) then consumer of X1 → id_op1=0x10 while the producer is in stage 0, stall=0.
- Load-use: LDUR X2, then consumer of X2 → stall=1 for one cycle, stage 0 bubble. Next cycle id_op2 = mem_rdata (0xDEAD), stall=0.
- Youngest wins: writes to X3 of 5, then 7, in stages 2 and 1 → id_op1=7. After the first retires, wb_we=1, wb_rd=3, wb_data=5.
- XZR: producer with id_rd=31 and consumer reading X31 → no forward, id_op = id_rf (0), wb_we never asserted.
- Flush: id_valid=1, flush=1 with a pending hazard → stall=0, no wb_we DEPTH cycles later.
- Reset mid-flight with 3 valid entries → wb_we=0 for DEPTH following cycles and all outputs at reset values.
